// File: rtl/lnet_pkg.sv
// -----------------------------------------------------------------------------
// lnet_pkg
// Shared types and widths for the LUT-network layer controller.
//   state_t    : controller FSM states (IDLE / EVAL / HOLD)
//   LAT_CNT_W  : width of the LUT latency down-counter
//   PERF_CNT_W : width of the optional performance counters
// -----------------------------------------------------------------------------
package lnet_pkg;

   localparam int LAT_CNT_W  = 4;
   localparam int PERF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/lnet_perf_cnt.sv
// -----------------------------------------------------------------------------
// lnet_perf_cnt
// Output-side performance counters for lnet_layer_ctrl. Only instantiated when
// the LNET_PERF_CNT_EN macro is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   m_valid    : layer result valid (observed)
//   m_ready    : downstream ready (observed)
//   vec_cnt    : completed m-side transfers, wraps 0xFFFF -> 0
//   stall_cnt  : cycles with m_valid=1 and m_ready=0, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module lnet_perf_cnt
   import lnet_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m_valid,
   input  logic                  m_ready,
   output logic [PERF_CNT_W-1:0] vec_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         // Free-running wrap on the transfer counter.
         if (m_valid && m_ready)
            vec_cnt <= vec_cnt + 1'b1;
         // Stall counter sticks at all-ones rather than wrapping.
         if (m_valid && !m_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lnet_layer_ctrl.sv
// -----------------------------------------------------------------------------
// lnet_layer_ctrl
// Handshake controller wrapped around a (possibly pipelined) neuron LUT array.
// Accepts one activation vector, drives it into the LUT array, waits LUT_LAT
// cycles, captures the result and presents it downstream. A new vector may be
// accepted on the same edge the previous result is consumed.
//
// Parameters
//   IN_W    : activation width fed to the LUT array
//   OUT_W   : neuron output width returned by the LUT array
//   LUT_LAT : LUT array pipeline depth in cycles (0..15, 0 = combinational)
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : upstream handshake, s_data activation vector
//   lut_in / lut_out  : registered vector to LUT array / its result
//   m_valid/m_ready   : downstream handshake, m_data registered result
//   busy              : high whenever the FSM is not IDLE
//   vec_cnt/stall_cnt : performance counters, present only with
//                       LNET_PERF_CNT_EN defined
// -----------------------------------------------------------------------------
module lnet_layer_ctrl
   import lnet_pkg::*;
#(
   parameter int unsigned IN_W    = 8,
   parameter int unsigned OUT_W   = 8,
   parameter int unsigned LUT_LAT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IN_W-1:0]       s_data,
   output logic [IN_W-1:0]       lut_in,
   input  logic [OUT_W-1:0]      lut_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_W-1:0]      m_data,
   output logic                  busy
`ifdef LNET_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] vec_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

   if (LUT_LAT > 15) begin : g_bad_lat
      $error("lnet_layer_ctrl: LUT_LAT must be in 0..15");
   end

   localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LUT_LAT);

   state_t               state;
   state_t               state_nxt;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic                 accept;
   logic                 capture;

   assign accept  = s_valid && s_ready;
   assign capture = (state == EVAL) && (lat_cnt == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (s_valid) state_nxt = EVAL;
         EVAL: if (lat_cnt == '0) state_nxt = HOLD;
         HOLD: if (m_ready) state_nxt = s_valid ? EVAL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs. s_ready is gated by rst_n so it reads 0 throughout reset even
   // though the state register already sits in IDLE.
   always_comb begin
      s_ready = 1'b0;
      unique case (state)
         IDLE:    s_ready = rst_n;
         HOLD:    s_ready = rst_n & m_ready;
         default: s_ready = 1'b0;
      endcase
      m_valid = (state == HOLD);
      busy    = (state != IDLE);
   end

   // Datapath: LUT input register, latency counter, result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_in  <= '0;
         lat_cnt <= '0;
         m_data  <= '0;
      end else begin
         // An accept from HOLD reloads the counter, overriding the idle 0.
         if (accept) begin
            lut_in  <= s_data;
            lat_cnt <= LAT_INIT;
         end else if ((state == EVAL) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (capture)
            m_data <= lut_out;
      end
   end

`ifdef LNET_PERF_CNT_EN
   lnet_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .vec_cnt   (vec_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule
